// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle fetch/decode/execute controller for a 9-bit accumulator CPU
//
// Purpose: sequences IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT, holds the PC and the
// instruction register, and drives the ALU, register-file, LUT and memory
// strobes from the latched instruction.
//
// Optional feature: define CPU_CONTROLLER_CYCLE_COUNT_EN to add the 16-bit
// saturating CycleCount output.
//
// Ports:
//   Clk, ResetN        clock, asynchronous active-low reset
//   Start              begin program at PC=0 (ignored while Busy)
//   InstAddr/InstData  instruction memory address (PC) / returned word
//   Type, RTypeOP, ITypeOP, ImmediateOut, RegIdx   ALU and register fields
//   CondBranch         ALU conditional result, sampled in EXEC
//   LutIdx/TargetIn    branch-target LUT index / returned target
//   AccWrEn, AccSelMem, RegWrEn, MemRdEn, MemWrEn  datapath strobes
//   Busy, Done         running / halted status
//   CycleCount         busy-cycle counter (optional)

module cpu_controller (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       Start,
  output logic [7:0] InstAddr,
  input  logic [8:0] InstData,
  output logic       Type,
  output logic [3:0] RTypeOP,
  output logic [2:0] ITypeOP,
  output logic [4:0] ImmediateOut,
  output logic [3:0] RegIdx,
  input  logic       CondBranch,
  output logic [4:0] LutIdx,
  input  logic [7:0] TargetIn,
  output logic       AccWrEn,
  output logic       AccSelMem,
  output logic       RegWrEn,
  output logic       MemRdEn,
  output logic       MemWrEn,
  output logic       Busy,
  output logic       Done
`ifdef CPU_CONTROLLER_CYCLE_COUNT_EN
  ,
  output logic [15:0] CycleCount
`endif
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } stateT;

  stateT      state;
  stateT      nextState;
  logic [7:0] pc;
  logic [8:0] instReg;
  logic       condLatched;

  // Opcode classification from the latched instruction (bit 8 = I-type).
  logic isRType, isLoad, isStr, isMvto, isBtru, isB, isHaltWord, takeBranch;

  assign isRType    = ~instReg[8];
  assign isLoad     = isRType && (instReg[7:4] == 4'd1);
  assign isStr      = isRType && (instReg[7:4] == 4'd8);
  assign isMvto     = isRType && (instReg[7:4] == 4'd3);
  assign isBtru     = isRType && (instReg[7:4] == 4'd11);
  assign isB        = instReg[8] && (instReg[7:5] == 3'd3);
  assign isHaltWord = (instReg == 9'h1FF);
  assign takeBranch = isB || (isBtru && condLatched);

  assign InstAddr     = pc;
  assign Type         = instReg[8];
  assign RTypeOP      = instReg[7:4];
  assign ITypeOP      = instReg[7:5];
  assign ImmediateOut = instReg[4:0];
  assign RegIdx       = instReg[3:0];
  assign LutIdx       = instReg[4:0];

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      pc          <= 8'd0;
      instReg     <= 9'd0;
      condLatched <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE, HALT: if (Start) pc <= 8'd0;
        DECODE:     instReg <= InstData;
        EXEC:       condLatched <= CondBranch;
        // The halt word leaves the PC alone; restart reloads it anyway.
        WB:         if (!isHaltWord) pc <= takeBranch ? TargetIn : pc + 8'd1;
        default:    ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    AccWrEn   = 1'b0;
    AccSelMem = 1'b0;
    RegWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    MemWrEn   = 1'b0;
    Busy      = (state != IDLE) && (state != HALT);
    Done      = (state == HALT);
    case (state)
      IDLE, HALT: if (Start) nextState = FETCH;
      FETCH:      nextState = DECODE;
      DECODE:     nextState = EXEC;
      EXEC:       nextState = (isLoad || isStr) ? MEM : WB;
      MEM: begin
        nextState = WB;
        MemRdEn   = isLoad;
        MemWrEn   = isStr;
      end
      WB: begin
        nextState = isHaltWord ? HALT : FETCH;
        if (!isHaltWord) begin
          AccWrEn   = !(isStr || isBtru || isB || isMvto);
          AccSelMem = isLoad;
          RegWrEn   = isMvto;
        end
      end
      default:    nextState = IDLE;
    endcase
  end

`ifdef CPU_CONTROLLER_CYCLE_COUNT_EN
  logic [15:0] cycleCount;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      cycleCount <= 16'd0;
    end else if (((state == IDLE) || (state == HALT)) && Start) begin
      cycleCount <= 16'd0;
    end else if (Busy && (cycleCount != 16'hFFFF)) begin
      cycleCount <= cycleCount + 16'd1;
    end
  end

  assign CycleCount = cycleCount;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller
module tb_cpu_controller;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [7:0] instAddr;
  logic [8:0] instData;
  logic       dutType;
  logic [3:0] rTypeOp;
  logic [2:0] iTypeOp;
  logic [4:0] immOut;
  logic [3:0] regIdx;
  logic       cond;
  logic [4:0] lutIdx;
  logic [7:0] targetIn;
  logic       accWrEn, accSelMem, regWrEn, memRdEn, memWrEn, busy, done;
`ifdef CPU_CONTROLLER_CYCLE_COUNT_EN
  logic [15:0] cycleCount;
`endif

  logic [8:0] imem [256];
  logic [7:0] lut  [32];

  int nCmp = 0;
  int nErr = 0;

  assign instData = imem[instAddr];
  assign targetIn = lut[lutIdx];

  cpu_controller dut (
    .Clk(clk), .ResetN(rstN), .Start(start),
    .InstAddr(instAddr), .InstData(instData),
    .Type(dutType), .RTypeOP(rTypeOp), .ITypeOP(iTypeOp),
    .ImmediateOut(immOut), .RegIdx(regIdx),
    .CondBranch(cond), .LutIdx(lutIdx), .TargetIn(targetIn),
    .AccWrEn(accWrEn), .AccSelMem(accSelMem), .RegWrEn(regWrEn),
    .MemRdEn(memRdEn), .MemWrEn(memWrEn), .Busy(busy), .Done(done)
`ifdef CPU_CONTROLLER_CYCLE_COUNT_EN
    , .CycleCount(cycleCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic bit mIsLoad(input logic [8:0] i); return !i[8] && i[7:4] == 4'd1;  endfunction
  function automatic bit mIsStr (input logic [8:0] i); return !i[8] && i[7:4] == 4'd8;  endfunction
  function automatic bit mIsMvto(input logic [8:0] i); return !i[8] && i[7:4] == 4'd3;  endfunction
  function automatic bit mIsBtru(input logic [8:0] i); return !i[8] && i[7:4] == 4'd11; endfunction
  function automatic bit mIsB   (input logic [8:0] i); return  i[8] && i[7:5] == 3'd3;  endfunction
  function automatic int mLen(input logic [8:0] i);
    return (mIsLoad(i) || mIsStr(i)) ? 5 : 4;
  endfunction

  logic        mRun, mDone, mCond;
  logic [7:0]  mPc;
  logic [8:0]  mInst;
  logic [15:0] mCyc;
  int          mPhase;   // cycle index within the current instruction, 0 = FETCH

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mRun = 0; mDone = 0; mCond = 0; mPc = 0; mInst = 0; mCyc = 0; mPhase = 0;
    end else if (!mRun) begin
      if (start) begin
        mRun = 1; mDone = 0; mPc = 0; mPhase = 0; mCyc = 0;
      end
    end else begin
      if (mCyc != 16'hFFFF) mCyc = mCyc + 16'd1;
      if (mPhase == 1) mInst = imem[mPc];
      if (mPhase == 2) mCond = cond;
      if (mPhase == mLen(mInst) - 1) begin
        if (mInst == 9'h1FF) begin
          mRun = 0; mDone = 1;
        end else if (mIsB(mInst) || (mIsBtru(mInst) && mCond)) begin
          mPc = lut[mInst[4:0]];
        end else begin
          mPc = mPc + 8'd1;
        end
        mPhase = 0;
      end else begin
        mPhase++;
      end
    end
  end

  always @(negedge clk) begin
    bit eWb, eMem;
    eWb  = mRun && (mPhase == mLen(mInst) - 1) && (mInst != 9'h1FF);
    eMem = mRun && (mPhase == 3) && (mLen(mInst) == 5);
    chk("cmp Busy", {15'd0, busy}, {15'd0, mRun});
    chk("cmp Done", {15'd0, done}, {15'd0, mDone});
    chk("cmp InstAddr", {8'd0, instAddr}, {8'd0, mPc});
    chk("cmp AccWrEn", {15'd0, accWrEn}, {15'd0, eWb && !(mIsStr(mInst) || mIsBtru(mInst) || mIsB(mInst) || mIsMvto(mInst))});
    chk("cmp AccSelMem", {15'd0, accSelMem}, {15'd0, eWb && mIsLoad(mInst)});
    chk("cmp RegWrEn", {15'd0, regWrEn}, {15'd0, eWb && mIsMvto(mInst)});
    chk("cmp MemRdEn", {15'd0, memRdEn}, {15'd0, eMem && mIsLoad(mInst)});
    chk("cmp MemWrEn", {15'd0, memWrEn}, {15'd0, eMem && mIsStr(mInst)});
    if (mRun && mPhase >= 2) begin
      chk("cmp Type", {15'd0, dutType}, {15'd0, mInst[8]});
      chk("cmp RTypeOP", {12'd0, rTypeOp}, {12'd0, mInst[7:4]});
      chk("cmp ITypeOP", {13'd0, iTypeOp}, {13'd0, mInst[7:5]});
      chk("cmp ImmediateOut", {11'd0, immOut}, {11'd0, mInst[4:0]});
      chk("cmp RegIdx", {12'd0, regIdx}, {12'd0, mInst[3:0]});
      chk("cmp LutIdx", {11'd0, lutIdx}, {11'd0, mInst[4:0]});
    end
`ifdef CPU_CONTROLLER_CYCLE_COUNT_EN
    chk("cmp CycleCount", cycleCount, mCyc);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Returns positioned in the FETCH cycle of PC 0.
  task automatic pulseStart();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 60 && !done; i++) step();
    chk(name, {15'd0, done}, 16'd1);
  endtask

  initial begin
    int accN, accAt, doneAt;
    logic busyAt8;
    for (int i = 0; i < 256; i++) imem[i] = 9'h1FF;
    for (int i = 0; i < 32; i++) lut[i] = 8'h00;
    rstN = 1'b0; start = 1'b0; cond = 1'b0;
    repeat (3) step();
    chk("reset Busy", {15'd0, busy}, 16'd0);
    chk("reset Done", {15'd0, done}, 16'd0);
    chk("reset InstAddr", {8'd0, instAddr}, 16'd0);
    chk("reset AccWrEn", {15'd0, accWrEn}, 16'd0);
    rstN = 1'b1;
    step();
    chk("post-reset RegWrEn", {15'd0, regWrEn}, 16'd0);

    // Scenario 1: ADDI 5 then halt
    imem[0] = 9'h125; imem[1] = 9'h1FF;
    pulseStart();
    accN = 0; accAt = -1; doneAt = -1; busyAt8 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      if (accWrEn) begin
        accN++; accAt = c;
        chk("s1 Type", {15'd0, dutType}, 16'd1);
        chk("s1 ITypeOP", {13'd0, iTypeOp}, 16'd1);
        chk("s1 ImmediateOut", {11'd0, immOut}, 16'd5);
        chk("s1 AccSelMem", {15'd0, accSelMem}, 16'd0);
      end
      if (done && doneAt < 0) doneAt = c;
      if (c == 8) busyAt8 = busy;
`ifdef CPU_CONTROLLER_CYCLE_COUNT_EN
      if (c == 8 || c == 9) chk("s1 CycleCount", cycleCount, 16'd8);
`endif
    end
    chk("s1 AccWrEn count", 16'(accN), 16'd1);
    chk("s1 AccWrEn cycle", 16'(accAt), 16'd3);
    chk("s1 Done cycle", 16'(doneAt), 16'd8);
    chk("s1 Busy in HALT", {15'd0, busyAt8}, 16'd0);

    // Scenario 2: LOAD r2, with a Start pulse while busy
    imem[0] = 9'h012; imem[1] = 9'h1FF;
    pulseStart();
`ifdef CPU_CONTROLLER_CYCLE_COUNT_EN
    chk("s2 CycleCount cleared", cycleCount, 16'd0);
`endif
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      if (c == 1) start = 1'b1;
      if (c == 2) begin
        start = 1'b0;
        chk("s2 MemRdEn early", {15'd0, memRdEn}, 16'd0);
      end
      if (c == 3) begin
        chk("s2 MemRdEn", {15'd0, memRdEn}, 16'd1);
        chk("s2 MemWrEn", {15'd0, memWrEn}, 16'd0);
      end
      if (c == 4) begin
        chk("s2 AccWrEn", {15'd0, accWrEn}, 16'd1);
        chk("s2 AccSelMem", {15'd0, accSelMem}, 16'd1);
      end
      if (c == 5) chk("s2 next InstAddr", {8'd0, instAddr}, 16'd1);
    end
    waitDone("s2 halt");

    // Scenario 3: BTRU, CondBranch high only in EXEC -> taken
    imem[0] = 9'h0B5; imem[1] = 9'h1FF; imem[8'h40] = 9'h1FF; lut[21] = 8'h40;
    cond = 1'b0;
    pulseStart();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      if (c == 2) cond = 1'b1;
      if (c == 3) cond = 1'b0;
      if (c == 4) chk("s3 BTRU taken", {8'd0, instAddr}, 16'h40);
    end
    waitDone("s3a halt");

    // Same, CondBranch low only in EXEC -> not taken
    cond = 1'b1;
    pulseStart();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      if (c == 2) cond = 1'b0;
      if (c == 3) cond = 1'b1;
      if (c == 4) chk("s3 BTRU not taken", {8'd0, instAddr}, 16'h01);
    end
    cond = 1'b0;
    waitDone("s3b halt");

    // Scenario 4: B to 0xFE, undefined op, MVTO at 0xFF, wrap to 0
    lut[1] = 8'hFE;
    imem[0] = 9'h161; imem[8'hFE] = 9'h0F0; imem[8'hFF] = 9'h034;
    pulseStart();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) step();
      if (c == 4) begin
        chk("s4 B target", {8'd0, instAddr}, 16'hFE);
        imem[0] = 9'h1FF;
      end
      if (c == 7) begin
        chk("s4 undef AccWrEn", {15'd0, accWrEn}, 16'd1);
        chk("s4 undef AccSelMem", {15'd0, accSelMem}, 16'd0);
      end
      if (c == 8) chk("s4 InstAddr FF", {8'd0, instAddr}, 16'hFF);
      if (c == 11) chk("s4 MVTO RegWrEn", {15'd0, regWrEn}, 16'd1);
      if (c == 12) chk("s4 wrap", {8'd0, instAddr}, 16'h00);
    end
    waitDone("s4 halt");

    // Scenario 5: reset during MEM of STR
    imem[0] = 9'h083; imem[1] = 9'h1FF;
    pulseStart();
    repeat (3) step();
    chk("s5 MemWrEn in MEM", {15'd0, memWrEn}, 16'd1);
    rstN = 1'b0;
    #1;
    chk("s5 MemWrEn reset", {15'd0, memWrEn}, 16'd0);
    chk("s5 Busy reset", {15'd0, busy}, 16'd0);
    chk("s5 Done reset", {15'd0, done}, 16'd0);
    chk("s5 InstAddr reset", {8'd0, instAddr}, 16'd0);
    step();
    rstN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("s5 idle Busy", {15'd0, busy}, 16'd0);
      chk("s5 idle MemWrEn", {15'd0, memWrEn}, 16'd0);
      chk("s5 idle AccWrEn", {15'd0, accWrEn}, 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, compared %0d", nCmp);
    $fatal(1);
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have one clock (Clk); reset (ResetN) is asynchronous and active-low.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- Clk  in  1  rising-edge clock
- ResetN  in  1  async active-low reset
- Start  in  1  begin program at PC=0
- InstAddr  out  8  instruction memory address (PC)
- InstData  in  9  instruction word, valid the cycle after InstAddr changes
- Type  out  1  ALU type select (0=R, 1=I)
- RTypeOP  out  4  ALU R-op = InstData[7:4]
- ITypeOP  out  3  ALU I-op = InstData[7:5]
- ImmediateOut  out  5  ALU immediate = InstData[4:0]
- RegIdx  out  4  register-file index = InstData[3:0]
- CondBranch  in  1  ALU ConditionalBranch result
- LutIdx  out  5  branch-target LUT index = InstData[4:0]
- TargetIn  in  8  branch target from LUT
- AccWrEn  out  1  accumulator write strobe
- AccSelMem  out  1  accumulator source (1=data memory, 0=ALU Out)
- RegWrEn  out  1  register-file write strobe
- MemRdEn  out  1  data-memory read strobe
- MemWrEn  out  1  data-memory write strobe
- Busy  out  1  program executing
- Done  out  1  halt reached

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-004 Transitions SHALL be:
- IDLE->FETCH on Start=1, which also clears the PC to 0
- FETCH->DECODE and DECODE->EXEC unconditionally
- EXEC->MEM for LOAD (R op 1) and STR (R op 8); EXEC->WB otherwise
- MEM->WB unconditionally
- WB->FETCH, or WB->HALT when the latched instruction equals 9'h1FF
- HALT->FETCH on Start=1 (PC cleared to 0)
REQ-005 The block SHALL latch InstData into an internal instruction register in DECODE; in EXEC, MEM and WB, all ALU, register and LUT fields SHALL be driven from that latched value.
REQ-006 Latency SHALL be 4 cycles per non-memory instruction and 5 cycles per LOAD/STR, measured FETCH to next FETCH.
REQ-007 Write strobes SHALL be single-cycle pulses asserted only in WB, with these exceptions:
- MemWrEn (STR) pulses in MEM.
- MemRdEn (LOAD) is high for the whole MEM cycle.
REQ-008 Writeback SHALL be:
- LOAD: AccWrEn=1, AccSelMem=1
- MVTO (R op 3): RegWrEn=1
- STR, BTRU (R op 11), B (I op 3): no writeback
- all other opcodes: AccWrEn=1, AccSelMem=0
REQ-009 PC update in WB SHALL be:
- PC<=TargetIn for B
- PC<=TargetIn for BTRU when CondBranch was 1 in EXEC; CondBranch SHALL be sampled in EXEC only
- PC<=PC+1 otherwise, with 8'hFF wrapping to 8'h00
REQ-010 Busy SHALL be 1 in every state except IDLE and HALT; Done SHALL be 1 only in HALT.
REQ-011 Start SHALL be ignored while Busy=1.
REQ-012 The halt word 9'h1FF SHALL produce no writes and no memory access.
REQ-013 Undefined opcodes SHALL execute as non-memory, accumulator-writing instructions (ALU returns 0).

Reset
REQ-014 While ResetN=0, regardless of state (including mid-instruction), the block SHALL force:
- state=IDLE, PC=0, instruction register=0
- all strobes, Busy and Done = 0
REQ-015 No write strobe SHALL be asserted in the first cycle after ResetN deasserts.

Configuration
REQ-016 When CPU_CONTROLLER_CYCLE_COUNT_EN is defined, the block SHALL add output CycleCount (16 bits):
- cleared by reset and by an accepted Start
- increments every cycle while Busy=1
- holds in HALT and IDLE
- saturates at 16'hFFFF
REQ-017 When CPU_CONTROLLER_CYCLE_COUNT_EN is undefined, the CycleCount port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Program {ADDI 5, 9'h1FF}, Start pulse -> one AccWrEn with AccSelMem=0 and Type=1, ITypeOP=1, ImmediateOut=5; Done=1 exactly 8 cycles after FETCH of PC 0; Busy then 0.
- LOAD r2 at PC 0 -> MemRdEn=1 in cycle 4; AccWrEn=1 with AccSelMem=1 in cycle 5; next FETCH at cycle 6 with InstAddr=1.
- BTRU with CondBranch=1, TargetIn=8'h40 -> InstAddr=8'h40 at next FETCH. Same with CondBranch=0 -> InstAddr=PC+1.
- Instruction stream reaching PC=8'hFF with no branch -> next InstAddr=8'h00.
- ResetN low during MEM of a STR -> all strobes 0 immediately; state IDLE; after release, no activity until Start.
- With CPU_CONTROLLER_CYCLE_COUNT_EN defined, the two-instruction program of the first scenario -> CycleCount=8 in HALT; holds at 8; clears on the next Start.
